// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, read-side state encoding and the
// 6-bit bit-reverse used to undo the butterfly output ordering.
package fft_pkg;

   localparam int FFT_N     = 64;
   localparam int FFT_LOG2N = 6;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_STREAM = 2'd1,
      RD_DRAIN  = 2'd2
   } rd_state_t;

   function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] a);
      logic [FFT_LOG2N-1:0] r;
      r = {FFT_LOG2N{1'b0}};
      for (int b = 0; b < FFT_LOG2N; b++) begin
         r[b] = a[FFT_LOG2N-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft64_out_reorder_if.sv
// Stream bundle between the FFT result port, the reorder buffer and the
// downstream demapper. The slave side is the reorder block itself.
interface fft64_out_reorder_if #(parameter int WIDTH = 11);

   logic             in_valid;
   logic [WIDTH-1:0] in_r;
   logic [WIDTH-1:0] in_i;
   logic             rd_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] out_i;
   logic [5:0]       out_idx;
   logic             out_last;
   logic             overflow;

   modport master (
      output in_valid, in_r, in_i, out_ready,
      input  rd_en, out_valid, out_r, out_i, out_idx, out_last, overflow
   );

   modport slave (
      input  in_valid, in_r, in_i, out_ready,
      output rd_en, out_valid, out_r, out_i, out_idx, out_last, overflow
   );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two 64-entry register-array banks holding complex words. One synchronous
// write port and one asynchronous read port; contents are not reset.
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int WIDTH = 11
) (
   input  logic                 CLK,
   input  logic                 we,
   input  logic                 wbank,
   input  logic [FFT_LOG2N-1:0] waddr,
   input  logic [2*WIDTH-1:0]   wdata,
   input  logic                 rbank,
   input  logic [FFT_LOG2N-1:0] raddr,
   output logic [2*WIDTH-1:0]   rdata
);

   logic [2*WIDTH-1:0] mem_r [0:2*FFT_N-1];

   // Write port: bank select is the top address bit.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem_r[{wbank, waddr}] <= wdata;
      end
   end

   assign rdata = mem_r[{rbank, raddr}];

endmodule

// File: rtl/fft64_out_reorder.sv
// Receive-side reorder buffer for the 64-point FFT. Serial results are
// written into a free ping-pong bank (optionally at bit-reversed addresses)
// and full banks are replayed in natural or fft-shifted bin order.
module fft64_out_reorder
#(
   parameter int WIDTH    = 11,
   parameter bit BITREV   = 1'b1,
   parameter bit FFTSHIFT = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   fft64_out_reorder_if.slave bus
);

   import fft_pkg::*;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] i;
   } cword_t;

   localparam logic [FFT_LOG2N-1:0] RD_XOR   = FFTSHIFT ? 6'd32 : 6'd0;
   localparam logic [FFT_LOG2N-1:0] LAST_CNT = 6'd63;

   logic [1:0]           full_r;
   logic                 wr_bank_r;
   logic                 rd_bank_r;
   logic [FFT_LOG2N-1:0] wr_cnt_r;
   logic [FFT_LOG2N-1:0] rd_cnt_r;
   rd_state_t            state_r;
   logic                 out_valid_r;
   logic                 out_last_r;
   logic [FFT_LOG2N-1:0] out_idx_r;
   cword_t               out_word_r;
   logic                 overflow_r;

   logic                 wr_fire_s;
   logic                 wr_done_s;
   logic [FFT_LOG2N-1:0] wr_addr_s;
   cword_t               wr_word_s;
   logic                 load_s;
   logic                 rd_done_s;
   logic [FFT_LOG2N-1:0] rd_addr_s;
   cword_t               rd_word_s;

   // Write/read addressing and the output-register load decision.
   always_comb begin
      wr_fire_s   = bus.in_valid && !full_r[wr_bank_r];
      wr_done_s   = wr_fire_s && (wr_cnt_r == LAST_CNT);
      wr_addr_s   = BITREV ? bitrev6(wr_cnt_r) : wr_cnt_r;
      wr_word_s.r = bus.in_r;
      wr_word_s.i = bus.in_i;
      rd_addr_s   = rd_cnt_r ^ RD_XOR;
      load_s      = 1'b0;
      case (state_r)
         RD_IDLE:   load_s = full_r[rd_bank_r];
         RD_STREAM: load_s = !out_valid_r || bus.out_ready;
         RD_DRAIN:  load_s = bus.out_ready && full_r[rd_bank_r];
         default:   load_s = 1'b0;
      endcase
      rd_done_s = load_s && (rd_cnt_r == LAST_CNT);
   end

   // Writer: arrival counter, bank toggle and sticky overflow on a full bank.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_cnt_r   <= 6'd0;
         wr_bank_r  <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_fire_s) begin
            wr_cnt_r <= wr_cnt_r + 6'd1;
            if (wr_done_s) begin
               wr_bank_r <= ~wr_bank_r;
            end
         end
         if (bus.in_valid && full_r[wr_bank_r]) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Bank full flags: writer sets its bank, reader clears the other one.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         full_r <= 2'b00;
      end else begin
         if (wr_done_s) begin
            full_r[wr_bank_r] <= 1'b1;
         end
         if (rd_done_s) begin
            full_r[rd_bank_r] <= 1'b0;
         end
      end
   end

   // Read FSM with registered output word, index and last flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r     <= RD_IDLE;
         rd_bank_r   <= 1'b0;
         rd_cnt_r    <= 6'd0;
         out_valid_r <= 1'b0;
         out_word_r  <= {(2*WIDTH){1'b0}};
         out_idx_r   <= 6'd0;
         out_last_r  <= 1'b0;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_word_r  <= rd_word_s;
         out_idx_r   <= rd_addr_s;
         out_last_r  <= (rd_cnt_r == LAST_CNT);
         rd_cnt_r    <= rd_cnt_r + 6'd1;
         if (rd_done_s) begin
            rd_bank_r <= ~rd_bank_r;
            state_r   <= RD_DRAIN;
         end else begin
            state_r   <= RD_STREAM;
         end
      end else begin
         case (state_r)
            RD_DRAIN: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
                  state_r     <= RD_IDLE;
               end
            end
            RD_IDLE, RD_STREAM: begin
               state_r <= state_r;
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= RD_IDLE;
            end
         endcase
      end
   end

   fft_pingpong_ram #(.WIDTH(WIDTH)) u_ram (
      .CLK   (CLK),
      .we    (wr_fire_s),
      .wbank (wr_bank_r),
      .waddr (wr_addr_s),
      .wdata (wr_word_s),
      .rbank (rd_bank_r),
      .raddr (rd_addr_s),
      .rdata (rd_word_s)
   );

   assign bus.rd_en     = ~full_r[wr_bank_r];
   assign bus.out_valid = out_valid_r;
   assign bus.out_r     = out_word_r.r;
   assign bus.out_i     = out_word_r.i;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_last  = out_last_r;
   assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_fft64_out_reorder.sv
// Directed bench for the FFT output reorder buffer: instance A uses
// bit-reversed writes in natural order, instance B uses linear writes with
// fft-shifted replay.
module tb_fft64_out_reorder;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   fft64_out_reorder_if #(.WIDTH(11)) busA ();
   fft64_out_reorder_if #(.WIDTH(11)) busB ();

   fft64_out_reorder #(.WIDTH(11), .BITREV(1'b1), .FFTSHIFT(1'b0)) dutA (
      .CLK(CLK), .RST(RST), .bus(busA));
   fft64_out_reorder #(.WIDTH(11), .BITREV(1'b0), .FFTSHIFT(1'b1)) dutB (
      .CLK(CLK), .RST(RST), .bus(busB));

   typedef struct {int idx; int last; int r; int i; int stamp;} cap_t;
   typedef struct {int idx; int last; int r; int i;} exp_t;
   typedef struct {int pos; int idx; int r; int i; int last;} vec_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   rdy_mode = 1;
   int   ph = 0;
   int   nin = 0;
   int   fbuf [64];
   cap_t capA [$];
   cap_t capB [$];
   exp_t expq [$];
   vec_t tabA [8];
   vec_t tabB [6];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int tb_rev(input int k);
      int r;
      r = 0;
      for (int b = 0; b < 6; b++) if (k[b]) r = r | (1 << (5 - b));
      return r;
   endfunction

   function automatic int neg11(input int v);
      return (2048 - v) % 2048;
   endfunction

   function automatic int snapA();
      return int'({busA.out_valid, busA.out_idx, busA.out_last, busA.out_r, busA.out_i});
   endfunction

   // Reference model: a complete frame yields 64 words in bin order.
   task automatic model_push(input int v);
      exp_t e;
      fbuf[nin] = v;
      nin++;
      if (nin == 64) begin
         for (int k = 0; k < 64; k++) begin
            e.idx  = k;
            e.last = (k == 63) ? 1 : 0;
            e.r    = fbuf[tb_rev(k)];
            e.i    = neg11(e.r);
            expq.push_back(e);
         end
         nin = 0;
      end
   endtask

   task automatic sendA(input int v);
      int g;
      g = 0;
      while (!busA.rd_en && g < 2000) begin
         @(posedge CLK); #1;
         g++;
      end
      if (g >= 2000) check("rd_en_wait_timeout", 0, 1);
      busA.in_valid = 1'b1;
      busA.in_r     = 11'(v);
      busA.in_i     = 11'(neg11(v));
      model_push(v);
      @(posedge CLK); #1;
      busA.in_valid = 1'b0;
   endtask

   task automatic wait_cap(input int n, input int lim);
      int g;
      g = 0;
      while (capA.size() < n && g < lim) begin
         @(posedge CLK); #1;
         g++;
      end
      check("capture_count", capA.size(), n);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      expq.delete();
      nin = 0;
      capA.delete();
      capB.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   // out_ready driver: 0 = stall, 1 = always ready, 2 = 1,0,0,1 pattern
   initial begin
      busA.out_ready = 1'b1;
      forever begin
         @(posedge CLK); #1;
         case (rdy_mode)
            0: busA.out_ready = 1'b0;
            1: busA.out_ready = 1'b1;
            default: begin
               busA.out_ready = (ph == 0 || ph == 3);
               ph = (ph + 1) % 4;
            end
         endcase
      end
   end

   // Monitor A: scoreboard each handshake and check holds while stalled.
   initial begin
      int   prev;
      bit   stall;
      cap_t c;
      exp_t e;
      prev  = 0;
      stall = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            if (stall) check("hold_stable", snapA(), prev);
            if (busA.out_valid && busA.out_ready) begin
               c.idx = int'(busA.out_idx); c.last = int'(busA.out_last);
               c.r = int'(busA.out_r); c.i = int'(busA.out_i); c.stamp = cyc;
               capA.push_back(c);
               if (expq.size() == 0) begin
                  check("unexpected_word", c.idx, -1);
               end else begin
                  e = expq.pop_front();
                  check("word_idx", c.idx, e.idx);
                  check("word_last", c.last, e.last);
                  check("word_r", c.r, e.r);
                  check("word_i", c.i, e.i);
               end
            end
            stall = busA.out_valid && !busA.out_ready;
            prev  = snapA();
         end else begin
            stall = 1'b0;
         end
      end
   end

   // Monitor B: capture handshakes only.
   initial begin
      cap_t c;
      forever begin
         @(negedge CLK);
         if (RST && busB.out_valid && busB.out_ready) begin
            c.idx = int'(busB.out_idx); c.last = int'(busB.out_last);
            c.r = int'(busB.out_r); c.i = int'(busB.out_i); c.stamp = cyc;
            capB.push_back(c);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_low;
      int g;
      int lasts;
      busA.in_valid = 1'b0; busA.in_r = 11'd0; busA.in_i = 11'd0;
      busB.in_valid = 1'b0; busB.in_r = 11'd0; busB.in_i = 11'd0;
      busB.out_ready = 1'b1;

      tabA[0] = '{0, 0, 0, 0, 0};        tabA[1] = '{1, 1, 32, 2016, 0};
      tabA[2] = '{2, 2, 16, 2032, 0};    tabA[3] = '{3, 3, 48, 2000, 0};
      tabA[4] = '{31, 31, 62, 1986, 0};  tabA[5] = '{32, 32, 1, 2047, 0};
      tabA[6] = '{62, 62, 31, 2017, 0};  tabA[7] = '{63, 63, 63, 1985, 1};
      tabB[0] = '{0, 32, 32, 2016, 0};   tabB[1] = '{1, 33, 33, 2015, 0};
      tabB[2] = '{31, 63, 63, 1985, 0};  tabB[3] = '{32, 0, 0, 0, 0};
      tabB[4] = '{33, 1, 1, 2047, 0};    tabB[5] = '{63, 31, 31, 2017, 1};

      // reset values
      repeat (2) @(posedge CLK);
      #1;
      check("rst_rd_en", int'(busA.rd_en), 1);
      check("rst_out_valid", int'(busA.out_valid), 0);
      check("rst_out_r", int'(busA.out_r), 0);
      check("rst_out_i", int'(busA.out_i), 0);
      check("rst_out_idx", int'(busA.out_idx), 0);
      check("rst_out_last", int'(busA.out_last), 0);
      check("rst_overflow", int'(busA.overflow), 0);
      RST = 1'b1;

      // single frame, bit-reversed, with latency check
      rdy_mode = 1;
      do_reset();
      for (int n = 0; n < 64; n++) sendA(n);
      check("lat_pre_valid", int'(busA.out_valid), 0);
      @(posedge CLK); #1;
      check("lat_valid", int'(busA.out_valid), 1);
      check("lat_first_idx", int'(busA.out_idx), 0);
      wait_cap(64, 300);
      for (int t = 0; t < 8; t++) begin
         check("tabA_idx", capA[tabA[t].pos].idx, tabA[t].idx);
         check("tabA_r", capA[tabA[t].pos].r, tabA[t].r);
         check("tabA_i", capA[tabA[t].pos].i, tabA[t].i);
         check("tabA_last", capA[tabA[t].pos].last, tabA[t].last);
      end
      check("single_exp_empty", expq.size(), 0);

      // three frames back-to-back
      do_reset();
      rd_low = 0;
      for (int m = 0; m < 192; m++) begin
         if (!busA.rd_en) rd_low++;
         sendA(100 + m);
      end
      check("b2b_rd_en_drops", rd_low, 0);
      wait_cap(192, 500);
      check("b2b_contiguous", capA[191].stamp - capA[0].stamp, 191);
      check("b2b_overflow", int'(busA.overflow), 0);
      check("b2b_exp_empty", expq.size(), 0);

      // backpressure 1,0,0,1
      do_reset();
      rdy_mode = 2;
      for (int m = 0; m < 128; m++) sendA(300 + m);
      check("bp_rd_en_low", int'(busA.rd_en), 0);
      g = 0;
      while (!busA.rd_en && g < 2000) begin
         @(posedge CLK); #1;
         g++;
      end
      check("bp_words_before_free", capA.size(), 63);
      for (int m = 0; m < 64; m++) sendA(428 + m);
      wait_cap(192, 1500);
      check("bp_exp_empty", expq.size(), 0);
      rdy_mode = 1;

      // overflow with both banks full
      do_reset();
      rdy_mode = 0;
      for (int m = 0; m < 128; m++) sendA(500 + m);
      check("ovf_rd_en_low", int'(busA.rd_en), 0);
      busA.in_valid = 1'b1; busA.in_r = 11'd2047; busA.in_i = 11'd1;
      @(posedge CLK); #1;
      busA.in_valid = 1'b0;
      check("ovf_set", int'(busA.overflow), 1);
      repeat (5) @(posedge CLK);
      #1;
      check("ovf_sticky", int'(busA.overflow), 1);
      check("ovf_no_output_stalled", capA.size(), 0);
      rdy_mode = 1;
      wait_cap(128, 600);
      check("ovf_sticky_after_drain", int'(busA.overflow), 1);
      for (int m = 0; m < 64; m++) sendA(700 + m);
      wait_cap(192, 600);
      check("ovf_exp_empty", expq.size(), 0);

      // fft-shifted replay on instance B
      do_reset();
      for (int n = 0; n < 64; n++) begin
         busB.in_valid = 1'b1;
         busB.in_r = 11'(n);
         busB.in_i = 11'(neg11(n));
         @(posedge CLK); #1;
      end
      busB.in_valid = 1'b0;
      g = 0;
      while (capB.size() < 64 && g < 300) begin
         @(posedge CLK); #1;
         g++;
      end
      check("shift_count", capB.size(), 64);
      for (int t = 0; t < 6; t++) begin
         check("tabB_idx", capB[tabB[t].pos].idx, tabB[t].idx);
         check("tabB_r", capB[tabB[t].pos].r, tabB[t].r);
         check("tabB_i", capB[tabB[t].pos].i, tabB[t].i);
         check("tabB_last", capB[tabB[t].pos].last, tabB[t].last);
      end
      lasts = 0;
      foreach (capB[k]) lasts += capB[k].last;
      check("shift_last_count", lasts, 1);

      // reset in the middle of the second frame
      do_reset();
      rdy_mode = 0;
      for (int m = 0; m < 104; m++) sendA(900 + m);
      check("mid_pre_valid", int'(busA.out_valid), 1);
      RST = 1'b0;
      #1;
      check("mid_rst_out_valid", int'(busA.out_valid), 0);
      check("mid_rst_rd_en", int'(busA.rd_en), 1);
      expq.delete();
      nin = 0;
      capA.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      rdy_mode = 1;
      for (int m = 0; m < 64; m++) sendA(1200 + m);
      wait_cap(64, 300);
      check("mid_first_r", capA[0].r, 1200);
      check("mid_first_idx", capA[0].idx, 0);
      check("mid_exp_empty", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
